// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } arb_port_t;

endpackage

// File: rtl/mem_wait_ctr.sv
// Down-counter that times the ACCESS phase; zero marks the final access cycle.
module mem_wait_ctr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    // Load on grant, count down while the access is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and load/store ports onto one memory.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | accept one request (Mealy grant), data favoured unless the
//          | previous grant was data and a fetch is waiting
//   ACCESS | drive latched address/data for WAIT_CYCLES cycles; the last
//          | cycle writes (store) or captures mem_rd (load/fetch)
//   RESP   | one-cycle rvalid on the granted port, then back to IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                WAIT_CYCLES = 1,
    parameter logic [WORD_W-1:0] TEXT_LIMIT  = 32'h400
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_fault,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wd,
    input  logic [WORD_W-1:0] mem_rd
);

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("mem_arbiter: WAIT_CYCLES must be >= 1");
        end
    endgenerate

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    arb_state_t        state_q, state_n;
    arb_port_t         port_q;
    logic [WORD_W-1:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
    logic              we_q, fault_q, last_was_data;
    logic              pick_d, pick_if, d_fault_now;
    logic              ctr_load, ctr_dec, ctr_zero, final_cycle;
    logic              unused_if_addr_bits;

    // Fetch addresses are word-forced, so their low bits carry nothing.
    assign unused_if_addr_bits = ^if_addr[1:0];

    assign pick_d      = d_req && !(last_was_data && if_req);
    assign pick_if     = if_req && !pick_d;
    assign d_fault_now = (d_addr[1:0] != 2'b00) || (d_we && (d_addr < TEXT_LIMIT));
    assign final_cycle = (state_q == ACCESS) && ctr_zero;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and Mealy grants.
    always_comb begin
        state_n = state_q;
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    d_gnt   = 1'b1;
                    state_n = d_fault_now ? RESP : ACCESS;
                end else if (pick_if) begin
                    if_gnt  = 1'b1;
                    state_n = ACCESS;
                end
            end
            ACCESS:  if (ctr_zero) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign ctr_load = (state_q == IDLE) && (state_n == ACCESS);
    assign ctr_dec  = (state_q == ACCESS) && !ctr_zero;

    mem_wait_ctr #(
        .WIDTH (CW)
    ) u_wait_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ctr_load),
        .dec      (ctr_dec),
        .load_val (CW'(WAIT_CYCLES - 1)),
        .zero     (ctr_zero)
    );

    // Capture the winning request on its grant edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_q        <= PORT_IF;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            fault_q       <= 1'b0;
            last_was_data <= 1'b0;
        end else if (d_gnt) begin
            port_q        <= PORT_D;
            addr_q        <= {d_addr[WORD_W-1:2], 2'b00};
            wdata_q       <= d_wdata;
            we_q          <= d_we;
            fault_q       <= d_fault_now;
            last_was_data <= 1'b1;
        end else if (if_gnt) begin
            port_q        <= PORT_IF;
            addr_q        <= {if_addr[WORD_W-1:2], 2'b00};
            we_q          <= 1'b0;
            fault_q       <= 1'b0;
            last_was_data <= 1'b0;
        end
    end

    // Register read data into the granted port at the end of the access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (final_cycle && !we_q) begin
            if (port_q == PORT_D) d_rdata_q  <= mem_rd;
            else                  if_rdata_q <= mem_rd;
        end
    end

    assign mem_we    = final_cycle && we_q;
    assign mem_addr  = addr_q;
    assign mem_wd    = wdata_q;
    assign if_rvalid = (state_q == RESP) && (port_q == PORT_IF);
    assign d_rvalid  = (state_q == RESP) && (port_q == PORT_D);
    assign d_fault   = d_rvalid && fault_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: two arbiters (WAIT_CYCLES 1 and 3), each with its own memory.
module tb_mem_arbiter;

    typedef struct {
        int          k;
        bit          is_d;
        logic [31:0] data;
        bit          fault;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        init_done;
    logic        rst_n     [2];
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_gnt    [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_gnt     [2];
    logic        d_rvalid  [2];
    logic [31:0] d_rdata   [2];
    logic        d_fault   [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wd    [2];
    logic [31:0] mem_rd    [2];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   we_cnt [2];
    int   wc     [2] = '{1, 3};
    exp_t sb [$];

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h2002_0005;
        return 32'h1000_0000 | 32'(i * 4);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [31:0] m [512];

        always_ff @(posedge clk) begin
            if (!init_done) begin
                for (int i = 0; i < 512; i++) m[i] <= init_word(i);
            end else if (mem_we[g]) begin
                m[mem_addr[g][10:2]] <= mem_wd[g];
            end
        end

        assign mem_rd[g] = m[mem_addr[g][10:2]];

        mem_arbiter #(
            .WAIT_CYCLES ((g == 0) ? 1 : 3),
            .TEXT_LIMIT  (32'h400)
        ) u_dut (
            .clk       (clk),
            .reset_n   (rst_n[g]),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .d_fault   (d_fault[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wd    (mem_wd[g]),
            .mem_rd    (mem_rd[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] out_bits(input int k);
        return {22'd0, if_gnt[k], if_rvalid[k], d_gnt[k], d_rvalid[k], d_fault[k],
                mem_we[k], |mem_addr[k], |mem_wd[k], |if_rdata[k], |d_rdata[k]};
    endfunction

    task automatic check_resp(input int k, input bit is_d);
        exp_t e;
        if (sb.size() == 0) begin
            chk(is_d ? "unexpected_d_rvalid" : "unexpected_if_rvalid", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("resp_source", 32'(k * 2 + int'(is_d)), 32'(e.k * 2 + int'(e.is_d)));
            chk("resp_data", is_d ? d_rdata[k] : if_rdata[k], e.data);
            chk("resp_fault", is_d ? 32'(d_fault[k]) : 32'd0, 32'(e.fault));
            chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Monitor: pops the scoreboard on every response, counts memory writes.
    initial begin
        we_cnt = '{0, 0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (mem_we[k] === 1'b1) we_cnt[k]++;
                if (if_rvalid[k] === 1'b1) check_resp(k, 1'b0);
                if (d_rvalid[k] === 1'b1) check_resp(k, 1'b1);
                if (d_fault[k] === 1'b1 && d_rvalid[k] !== 1'b1)
                    chk("fault_without_rvalid", 32'd1, 32'd0);
            end
        end
    end

    task automatic do_req(input int k, input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_data, input bit exp_fault,
                          input bit push, output int gcyc, output int waits);
        bit got = 1'b0;
        waits = 0;
        gcyc  = 0;
        if (is_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = addr;
        end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if ((is_d ? d_gnt[k] : if_gnt[k]) === 1'b1) begin
                got  = 1'b1;
                gcyc = cyc;
            end else begin
                waits++;
            end
        end
        if (!got) chk("gnt_timeout", 32'd0, 32'd1);
        else if (push) sb.push_back('{k, is_d, exp_data, exp_fault,
                                      gcyc + (exp_fault ? 1 : wc[k] + 1)});
        @(posedge clk);
        #1;
        if (is_d) d_req[k] = 1'b0;
        else      if_req[k] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (sb.size() != 0 && n < 50);
        #1;
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    int gd, gf, wd_n, wf_n, g1, w1, base;

    initial begin
        init_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 init_done = 1'b1;
        @(negedge clk);
        chk("reset_outputs_0", out_bits(0), 32'd0);
        chk("reset_outputs_1", out_bits(1), 32'd0);
        @(posedge clk);
        #1 rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Fetch word 0: grant in the request cycle, rvalid two cycles later.
        do_req(0, 0, 0, 32'h0, 32'h0, 32'h2002_0005, 0, 1, g1, w1);
        chk("if_gnt_same_cycle", 32'(w1), 32'd0);
        drain();

        // Both ports together with last_was_data=0: data first, fetch 3 cycles later.
        fork
            do_req(0, 1, 0, 32'h8, 32'h0, 32'h1000_0008, 0, 1, gd, wd_n);
            do_req(0, 0, 0, 32'h4, 32'h0, 32'h1000_0004, 0, 1, gf, wf_n);
        join
        chk("arb_data_first", 32'(gd < gf), 32'd1);
        chk("arb_next_gnt_gap", 32'(gf - gd), 32'd3);
        drain();

        // Store then load at the text boundary.
        base = we_cnt[0];
        do_req(0, 1, 1, 32'h400, 32'hDEAD_BEEF, 32'h1000_0008, 0, 1, g1, w1);
        drain();
        chk("store_we_one_cycle", 32'(we_cnt[0] - base), 32'd1);
        chk("store_mem_word", g_inst[0].m[256], 32'hDEAD_BEEF);
        do_req(0, 1, 0, 32'h400, 32'h0, 32'hDEAD_BEEF, 0, 1, g1, w1);
        drain();

        // Both ports after a data grant: fetch wins.
        fork
            do_req(0, 1, 0, 32'h10, 32'h0, 32'h1000_0010, 0, 1, gd, wd_n);
            do_req(0, 0, 0, 32'hC,  32'h0, 32'h1000_000C, 0, 1, gf, wf_n);
        join
        chk("arb_fetch_first", 32'(gf < gd), 32'd1);
        drain();

        // Protected store and misaligned load both fault without touching memory.
        base = we_cnt[0];
        do_req(0, 1, 1, 32'h10, 32'hBAD0_BAD0, 32'h1000_0010, 1, 1, g1, w1);
        drain();
        chk("fault_store_no_we", 32'(we_cnt[0] - base), 32'd0);
        chk("fault_store_word", g_inst[0].m[4], 32'h1000_0010);
        do_req(0, 1, 0, 32'h402, 32'h0, 32'h1000_0010, 1, 1, g1, w1);
        drain();

        // Fetch ignores the low address bits.
        do_req(0, 0, 0, 32'h403, 32'h0, 32'hDEAD_BEEF, 0, 1, g1, w1);
        drain();

        // WAIT_CYCLES=3: reset in the final ACCESS cycle of a store.
        base = we_cnt[1];
        do_req(1, 1, 1, 32'h404, 32'h1234_5678, 32'h0, 0, 0, g1, w1);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("final_cycle_we_high", 32'(mem_we[1]), 32'd1);
        rst_n[1] = 1'b0;
        #1;
        chk("reset_async_we_drop", 32'(mem_we[1]), 32'd0);
        @(negedge clk);
        chk("reset_mid_outputs", out_bits(1), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("reset_no_write", 32'(we_cnt[1] - base), 32'd0);
        chk("reset_word_kept", g_inst[1].m[257], 32'h1000_0404);
        rst_n[1] = 1'b1;

        // WAIT_CYCLES=3 load: address held through ACCESS, rvalid at gnt+4.
        do_req(1, 1, 0, 32'h404, 32'h0, 32'h1000_0404, 0, 1, g1, w1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait3_addr_stable", mem_addr[1], 32'h404);
        end
        drain();

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
